// File: rtl/uart_alu_ctrl.sv
// Sequencer between the UART rx/tx pair and the ALU: collects A, B, opcode, returns the result.
// Optional inter-byte frame timeout is enabled by defining UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
   parameter int N_BITS_DATA    = 8,
   parameter int N_BITS_OP      = 6,
   parameter int N_BITS_STATE   = 5,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int N_BITS_TIMEOUT = 20
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   rx_done_tick,
   input  logic [N_BITS_DATA-1:0] rx_data,
   input  logic                   tx_done_tick,
   input  logic [N_BITS_DATA-1:0] alu_result,
   output logic [N_BITS_DATA-1:0] alu_a,
   output logic [N_BITS_DATA-1:0] alu_b,
   output logic [N_BITS_OP-1:0]   alu_op,
   output logic                   tx_start,
   output logic [N_BITS_DATA-1:0] tx_data,
   output logic                   busy,
   output logic                   rx_overrun,
   output logic                   timeout
);

   typedef enum logic [N_BITS_STATE-1:0] {
      WAIT_A  = N_BITS_STATE'(5'b00001),
      WAIT_B  = N_BITS_STATE'(5'b00010),
      WAIT_OP = N_BITS_STATE'(5'b00100),
      EXEC    = N_BITS_STATE'(5'b01000),
      WAIT_TX = N_BITS_STATE'(5'b10000)
   } state_t;

   if ((64'd1 << N_BITS_TIMEOUT) < 64'(TIMEOUT_CYCLES)) begin : g_tmo_width_check
      $error("N_BITS_TIMEOUT too narrow for TIMEOUT_CYCLES");
   end

   state_t                 state_q, state_d;
   logic [N_BITS_DATA-1:0] alu_a_q, alu_a_d;
   logic [N_BITS_DATA-1:0] alu_b_q, alu_b_d;
   logic [N_BITS_OP-1:0]   alu_op_q, alu_op_d;
   logic [N_BITS_DATA-1:0] tx_data_q, tx_data_d;
   logic                   tx_start_q, tx_start_d;
   logic                   busy_q, busy_d;
   logic                   rx_overrun_q, rx_overrun_d;
   logic                   tmo_hit;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   logic [N_BITS_TIMEOUT-1:0] tmo_cnt_q, tmo_cnt_d;
   logic                      timeout_q, timeout_d;
   logic                      in_gap;

   // A byte arriving on the expiry cycle wins, so expiry is qualified by !rx_done_tick.
   always_comb begin
      in_gap    = (state_q == WAIT_B) || (state_q == WAIT_OP);
      tmo_hit   = in_gap && !rx_done_tick &&
                  (tmo_cnt_q == N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1));
      timeout_d = tmo_hit;
      tmo_cnt_d = '0;
      if (in_gap && !rx_done_tick && !tmo_hit) begin
         tmo_cnt_d = tmo_cnt_q + N_BITS_TIMEOUT'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      tx_data_d    = tx_data_q;
      tx_start_d   = 1'b0;
      rx_overrun_d = 1'b0;
      case (state_q)
         WAIT_A: begin
            if (rx_done_tick) begin
               alu_a_d = rx_data;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (rx_done_tick) begin
               alu_b_d = rx_data;
               state_d = WAIT_OP;
            end else if (tmo_hit) begin
               state_d = WAIT_A;
            end
         end
         WAIT_OP: begin
            if (rx_done_tick) begin
               alu_op_d = rx_data[N_BITS_OP-1:0];
               state_d  = EXEC;
            end else if (tmo_hit) begin
               state_d = WAIT_A;
            end
         end
         // alu_op has been stable for a full period here, so alu_result is settled.
         EXEC: begin
            tx_data_d    = alu_result;
            tx_start_d   = 1'b1;
            state_d      = WAIT_TX;
            rx_overrun_d = rx_done_tick;
         end
         WAIT_TX: begin
            rx_overrun_d = rx_done_tick;
            if (tx_done_tick) begin
               state_d = WAIT_A;
            end
         end
         default: state_d = WAIT_A;
      endcase
      busy_d = (state_d == EXEC) || (state_d == WAIT_TX);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= WAIT_A;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
         busy_q       <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         busy_q       <= busy_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign tx_data    = tx_data_q;
   assign tx_start   = tx_start_q;
   assign busy       = busy_q;
   assign rx_overrun = rx_overrun_q;

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the UART receiver/transmitter pair and the ALU in the TP2 datapath.
- Collects three received bytes in order: operand A, operand B, opcode. Drives them to the ALU as registered outputs.
- Captures the ALU result and hands it to the transmitter with a one-cycle start pulse.
- Accepts no new frame until the transmitter reports completion. Owns the receive/transmit handshakes and the recovery from a stalled frame.

Parameters:
- N_BITS_DATA, 8, width of the UART byte, the ALU operands and the ALU result.
- N_BITS_OP, 6, ALU opcode width; taken from the low bits of the third byte.
- N_BITS_STATE, 5, one-hot state register width.
- TIMEOUT_CYCLES, 1000000, maximum clock cycles allowed between bytes of one frame (used only with the optional feature).
- N_BITS_TIMEOUT, 20, timeout counter width; must satisfy 2^N_BITS_TIMEOUT >= TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- rx_done_tick  in  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  in  N_BITS_DATA  received byte.
- tx_done_tick  in  1  one-cycle pulse: transmitter has finished its frame.
- alu_result  in  N_BITS_DATA  combinational ALU output, computed from alu_a, alu_b and alu_op.
- alu_a  out  N_BITS_DATA  registered operand A.
- alu_b  out  N_BITS_DATA  registered operand B.
- alu_op  out  N_BITS_OP  registered opcode.
- tx_start  out  1  one-cycle pulse: start transmitting tx_data.
- tx_data  out  N_BITS_DATA  registered result byte.
- busy  out  1  high in EXEC and WAIT_TX.
- rx_overrun  out  1  one-cycle pulse: a byte was dropped.
- timeout  out  1  one-cycle pulse: frame aborted on inter-byte timeout.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state = WAIT_A.
  - alu_a, alu_b, alu_op, tx_data = 0.
  - tx_start, busy, rx_overrun, timeout = 0.
  - Timeout counter = 0.
  - Reset asserted mid-frame or mid-transmission aborts everything; no tx_start is issued afterwards.
- One-hot states: WAIT_A=00001, WAIT_B=00010, WAIT_OP=00100, EXEC=01000, WAIT_TX=10000. Any illegal encoding goes to WAIT_A on the next edge.
- WAIT_A: on rx_done_tick, alu_a <= rx_data; go to WAIT_B.
- WAIT_B: on rx_done_tick, alu_b <= rx_data; go to WAIT_OP.
- WAIT_OP: on rx_done_tick, alu_op <= rx_data[N_BITS_OP-1:0] (upper bits ignored); go to EXEC.
- EXEC: lasts exactly one cycle.
  - tx_data <= alu_result; tx_start <= 1; go to WAIT_TX.
  - ALU settling time is one full clock period from the alu_op update.
- WAIT_TX:
  - tx_start returns to 0 on the first edge in this state.
  - On tx_done_tick, go to WAIT_A.
- Latency: rx_done_tick for the opcode byte sampled at edge E0 → tx_start high during the cycle after E1, i.e. 2 edges after the opcode tick. tx_data is valid in the same cycle as tx_start and stays stable until the next EXEC.
- rx_done_tick in EXEC or WAIT_TX:
  - The byte is dropped and rx_overrun pulses for one cycle.
  - The state is unchanged, and no register other than rx_overrun changes.
- tx_done_tick outside WAIT_TX is ignored.
- Simultaneous rx_done_tick and tx_done_tick in WAIT_TX: the state goes to WAIT_A, the byte is dropped and rx_overrun pulses. A byte is accepted only in a WAIT_A/B/OP state.
- alu_a, alu_b and alu_op hold their values between frames; they are not cleared on frame completion.
- busy is the registered decode of the next state being EXEC or WAIT_TX, so it is high for the same cycles the state is EXEC or WAIT_TX.

Optional Feature:
- Macro: UART_ALU_CTRL_TIMEOUT_EN.
- When defined:
  - The counter increments every cycle in WAIT_B and WAIT_OP, and clears on every accepted byte and in all other states.
  - When the counter reaches TIMEOUT_CYCLES-1 without rx_done_tick, go to WAIT_A and pulse timeout for one cycle. Operands already captured are retained but unused.
  - rx_done_tick in that same cycle wins: the byte is accepted, no timeout.
- When not defined: no counter is synthesised, timeout is tied to 0, and the FSM waits indefinitely.

Test Plan:
- Bench ALU stub: alu_result = alu_a + alu_b.
- Frame bytes 0x05, 0x03, 0x20 → alu_a=0x05, alu_b=0x03, alu_op=6'h20; tx_data=0x08; tx_start high exactly 1 cycle, 2 edges after the third tick; busy=1 until tx_done_tick, then state=WAIT_A.
- Frame 0xFF, 0x02, 0xE0 → alu_op=6'h20 (upper bits dropped); tx_data=0x01 (8-bit wrap).
- Byte 0x77 sent during WAIT_TX, then tx_done_tick → rx_overrun one pulse; state=WAIT_A; next frame 0x01, 0x01, 0x20 gives tx_data=0x02 (0x77 not used as A).
- reset=0 for 1 cycle after the second byte of a frame → all outputs 0; a subsequent opcode byte is stored as alu_a; no tx_start.
- Back-to-back frames 0x10, 0x20, 0x20 and 0x30, 0x01, 0x20 with tx_done_tick between them → two tx_start pulses with tx_data 0x30 then 0x31.
- With UART_ALU_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, one byte then a 20-cycle gap → timeout pulses at cycle 16 after the byte; state=WAIT_A; next byte lands in alu_a.
